// File: rtl/axis_sa_sched_if.sv
// Bundles the command, buffer-read, array-stream and status signals of the systolic-array sequencer.
// The master modport is the sequencer's view; slave is the view of everything around it.
interface axis_sa_sched_if #(
    parameter int R  = 4,
    parameter int C  = 8,
    parameter int WX = 4,
    parameter int WK = 8,
    parameter int AW = 10,
    parameter int WN = 16
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WN-1:0]     cmd_kdim;
    logic [WN-1:0]     cmd_ntiles;
    logic [AW-1:0]     cmd_xbase;
    logic [AW-1:0]     cmd_kbase;
    logic              xbuf_en;
    logic [AW-1:0]     xbuf_addr;
    logic [R*WX-1:0]   xbuf_rdata;
    logic              kbuf_en;
    logic [AW-1:0]     kbuf_addr;
    logic [C*WK-1:0]   kbuf_rdata;
    logic              sa_s_valid;
    logic              sa_s_ready;
    logic              sa_s_last;
    logic [R*WX-1:0]   sa_sx_data;
    logic [C*WK-1:0]   sa_sk_data;
    logic              sa_m_valid;
    logic              sa_m_ready;
    logic              sa_m_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_kdim, cmd_ntiles, cmd_xbase, cmd_kbase,
        input  xbuf_rdata, kbuf_rdata, sa_s_ready, sa_m_valid, sa_m_ready, sa_m_last,
        output cmd_ready, xbuf_en, xbuf_addr, kbuf_en, kbuf_addr,
        output sa_s_valid, sa_s_last, sa_sx_data, sa_sk_data, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_kdim, cmd_ntiles, cmd_xbase, cmd_kbase,
        output xbuf_rdata, kbuf_rdata, sa_s_ready, sa_m_valid, sa_m_ready, sa_m_last,
        input  cmd_ready, xbuf_en, xbuf_addr, kbuf_en, kbuf_addr,
        input  sa_s_valid, sa_s_last, sa_sx_data, sa_sk_data, busy, done, err
    );
endinterface

// File: rtl/axis_sa_sched.sv
// Matmul command sequencer: reads X/K vectors from two 1-cycle-latency buffers, streams them as
// kdim-beat tiles into the array through a 2-entry skid, and limits tiles in flight to MAXO.
module axis_sa_sched #(
    parameter int R    = 4,
    parameter int C    = 8,
    parameter int WX   = 4,
    parameter int WK   = 8,
    parameter int AW   = 10,
    parameter int WN   = 16,
    parameter int MAXO = 2
) (
    input logic clk,
    input logic rst,
    axis_sa_sched_if.master bus
);
    localparam int OW = $clog2(MAXO + 1);
    localparam int SW = R*WX + C*WK + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          r_state;
    logic [WN-1:0]   r_kdim;
    logic [WN-1:0]   r_ntiles;
    logic [WN-1:0]   r_j;
    logic [WN-1:0]   r_t;
    logic [AW-1:0]   r_xptr;
    logic [AW-1:0]   r_kptr;
    logic [OW-1:0]   r_outs;
    logic            r_inflight;
    logic            r_inflightLast;
    logic [SW-1:0]   r_sk0;
    logic [SW-1:0]   r_sk1;
    logic [1:0]      r_occ;
    logic            r_err;

    logic            w_pop;
    logic [2:0]      w_level;
    logic            w_jLast;
    logic            w_tLast;
    logic            w_issue;
    logic            w_inc;
    logic            w_dec;
    logic            w_underflow;
    logic [OW-1:0]   w_outsNext;
    logic [1:0]      w_wrSlot;
    logic [SW-1:0]   w_pushData;

    assign w_pop      = (r_occ != 2'd0) && bus.sa_s_ready;
    // Skid occupancy once this cycle's returning read lands and the head possibly leaves.
    assign w_level    = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_jLast    = (r_j == r_kdim - WN'(1));
    assign w_tLast    = (r_t == r_ntiles - WN'(1));
    assign w_issue    = (r_state == RUN) && (w_level < 3'd2) &&
                        ((r_j != '0) || (r_outs < OW'(MAXO)));
    assign w_inc      = w_issue && (r_j == '0);
    assign w_dec      = bus.sa_m_valid && bus.sa_m_ready && bus.sa_m_last;
    assign w_underflow = w_dec && (r_outs == '0);
    assign w_wrSlot   = r_occ - {1'b0, w_pop};
    assign w_pushData = {bus.xbuf_rdata, bus.kbuf_rdata, r_inflightLast};

    always_comb begin
        w_outsNext = r_outs;
        case ({w_inc, w_dec && !w_underflow})
            2'b10:   w_outsNext = r_outs + OW'(1);
            2'b01:   w_outsNext = r_outs - OW'(1);
            default: w_outsNext = r_outs;
        endcase
    end

    assign bus.cmd_ready  = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.err        = r_err;
    assign bus.xbuf_en    = w_issue;
    assign bus.kbuf_en    = w_issue;
    assign bus.xbuf_addr  = r_xptr;
    assign bus.kbuf_addr  = r_kptr;
    assign bus.sa_s_valid = (r_occ != 2'd0);
    assign bus.sa_s_last  = r_sk0[0];
    assign bus.sa_sx_data = r_sk0[SW-1 -: R*WX];
    assign bus.sa_sk_data = r_sk0[C*WK:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_kdim         <= '0;
            r_ntiles       <= '0;
            r_j            <= '0;
            r_t            <= '0;
            r_xptr         <= '0;
            r_kptr         <= '0;
            r_outs         <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_sk0          <= '0;
            r_sk1          <= '0;
            r_occ          <= 2'd0;
            r_err          <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_jLast;
            r_outs         <= w_outsNext;
            r_occ          <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (bus.cmd_valid && r_state == IDLE) r_err <= 1'b0;
            if (w_underflow) r_err <= 1'b1;

            // Pop shifts the second entry forward; the returning read fills the first free slot.
            if (w_pop) r_sk0 <= r_sk1;
            if (r_inflight) begin
                if (w_wrSlot[0]) r_sk1 <= w_pushData;
                else             r_sk0 <= w_pushData;
            end

            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_kdim   <= bus.cmd_kdim;
                    r_ntiles <= bus.cmd_ntiles;
                    r_xptr   <= bus.cmd_xbase;
                    r_kptr   <= bus.cmd_kbase;
                    r_j      <= '0;
                    r_t      <= '0;
                    // Empty commands pass through DRAIN, which completes at once with nothing in flight.
                    r_state  <= (bus.cmd_kdim == '0 || bus.cmd_ntiles == '0) ? DRAIN : RUN;
                end
                RUN: if (w_issue) begin
                    r_xptr <= r_xptr + AW'(1);
                    r_kptr <= r_kptr + AW'(1);
                    if (w_jLast) begin
                        r_j <= '0;
                        if (w_tLast) r_state <= DRAIN;
                        else         r_t <= r_t + WN'(1);
                    end else begin
                        r_j <= r_j + WN'(1);
                    end
                end
                DRAIN: if (r_occ == 2'd0 && !r_inflight && w_outsNext == '0) r_state <= DONE;
                DONE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_sa_sched.sv
// Directed self-checking bench for axis_sa_sched with behavioural X/K buffers and an array model
// that answers every tile sent on the s side with C output beats.
module tb_axis_sa_sched;
    localparam int R = 4, C = 8, WX = 4, WK = 8, AW = 10, WN = 16, MAXO = 2;
    localparam int SW = R*WX + C*WK + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_sa_sched_if #(.R(R), .C(C), .WX(WX), .WK(WK), .AW(AW), .WN(WN)) bus ();

    axis_sa_sched #(.R(R), .C(C), .WX(WX), .WK(WK), .AW(AW), .WN(WN), .MAXO(MAXO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [R*WX-1:0] xData(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    function automatic logic [C*WK-1:0] kData(input logic [AW-1:0] a);
        return {8'hC3, 46'h0, a};
    endfunction

    // Buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.xbuf_en) bus.xbuf_rdata <= xData(bus.xbuf_addr);
        if (bus.kbuf_en) bus.kbuf_rdata <= kData(bus.kbuf_addr);
    end

    // Array model: each tile received produces C output beats, the last one flagged.
    int   pend;
    int   mBeat;
    logic forceM = 1'b0;
    logic modelValid;
    assign modelValid     = (pend != 0);
    assign bus.sa_m_valid = modelValid || forceM;
    assign bus.sa_m_last  = modelValid ? (mBeat == C-1) : forceM;

    always @(posedge clk) begin
        if (rst) begin
            pend  <= 0;
            mBeat <= 0;
        end else begin
            pend <= pend + ((bus.sa_s_valid && bus.sa_s_ready && bus.sa_s_last) ? 1 : 0)
                         - ((modelValid && bus.sa_m_ready && bus.sa_m_last) ? 1 : 0);
            if (modelValid && bus.sa_m_ready) mBeat <= bus.sa_m_last ? 0 : mBeat + 1;
        end
    end

    // s_ready driver: constant 1, or a 1,0,0,1 opening followed by random values.
    int       readyMode = 0;
    int       readyIdx  = 0;
    logic [3:0] readyPat = 4'b1001;
    always @(posedge clk) begin
        #1;
        if (readyMode == 0) begin
            bus.sa_s_ready = 1'b1;
        end else begin
            if (readyIdx < 4) bus.sa_s_ready = readyPat[readyIdx];
            else              bus.sa_s_ready = 1'($urandom_range(0, 1));
            readyIdx++;
        end
    end

    // Event log sampled mid-cycle.
    logic [AW-1:0] xq[$];
    logic [AW-1:0] kq[$];
    logic [SW-1:0] sq[$];
    int acceptCyc, firstReadCyc, firstValidCyc, doneCnt, doneCyc, mLastCnt, mLastCyc;
    int stableErrs, enMismatch;
    logic prevStall = 1'b0;
    logic [SW-1:0] prevBeat;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid && bus.cmd_ready) acceptCyc = cyc;
            if (bus.xbuf_en) begin
                if (xq.size() == 0) firstReadCyc = cyc;
                xq.push_back(bus.xbuf_addr);
                kq.push_back(bus.kbuf_addr);
            end
            if (bus.xbuf_en != bus.kbuf_en) enMismatch++;
            if (bus.sa_s_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (prevStall && (!bus.sa_s_valid ||
                {bus.sa_sx_data, bus.sa_sk_data, bus.sa_s_last} != prevBeat)) stableErrs++;
            prevStall = bus.sa_s_valid && !bus.sa_s_ready;
            prevBeat  = {bus.sa_sx_data, bus.sa_sk_data, bus.sa_s_last};
            if (bus.sa_s_valid && bus.sa_s_ready) sq.push_back(prevBeat);
            if (bus.done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (bus.sa_m_valid && bus.sa_m_ready && bus.sa_m_last) begin
                mLastCnt++;
                mLastCyc = cyc;
            end
        end
    end

    task automatic clearLog();
        xq.delete();
        kq.delete();
        sq.delete();
        acceptCyc = -1;
        firstReadCyc = -1;
        firstValidCyc = -1;
        doneCyc = -1;
        mLastCyc = -1;
        mLastCnt = 0;
        stableErrs = 0;
        enMismatch = 0;
    endtask

    task automatic applyStimulus(input logic [WN-1:0] kdim, input logic [WN-1:0] ntiles,
                                 input logic [AW-1:0] xb, input logic [AW-1:0] kb);
        clearLog();
        @(posedge clk); #1;
        bus.cmd_kdim   = kdim;
        bus.cmd_ntiles = ntiles;
        bus.cmd_xbase  = xb;
        bus.cmd_kbase  = kb;
        bus.cmd_valid  = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int start = doneCnt;
        int n = 0;
        while (doneCnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 128'(doneCnt - start), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic verifyAddrs(input logic [AW-1:0] xb, input logic [AW-1:0] kb,
                               input int total, output int errs);
        errs = 0;
        if (xq.size() != total) errs++;
        for (int i = 0; i < total && i < xq.size(); i++) begin
            if (xq[i] != xb + AW'(i)) errs++;
            if (kq[i] != kb + AW'(i)) errs++;
        end
    endtask

    task automatic verifyBeats(input logic [AW-1:0] xb, input logic [AW-1:0] kb,
                               input int kdim, input int total, output int errs);
        logic [SW-1:0] exp;
        errs = 0;
        if (sq.size() != total) errs++;
        for (int i = 0; i < total && i < sq.size(); i++) begin
            exp = {xData(xb + AW'(i)), kData(kb + AW'(i)), 1'((i % kdim) == kdim - 1)};
            if (sq[i] != exp) errs++;
        end
    endtask

    function automatic logic [6:0] statusVec();
        return {bus.cmd_ready, bus.busy, bus.sa_s_valid, bus.xbuf_en, bus.kbuf_en, bus.done, bus.err};
    endfunction

    initial begin
        int errs;
        int snap;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_kdim = '0;
        bus.cmd_ntiles = '0;
        bus.cmd_xbase = '0;
        bus.cmd_kbase = '0;
        bus.sa_m_ready = 1'b1;
        doneCnt = 0;
        clearLog();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_status", 128'(statusVec()), 128'(7'b1000000));
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single tile, kdim=3");
        applyStimulus(16'd3, 16'd1, 10'h010, 10'h020);
        waitDone("t1", 200);
        verifyAddrs(10'h010, 10'h020, 3, errs);
        checkOutput("t1_addrs", 128'(errs), 128'(0));
        checkOutput("t1_x_addr2", 128'(xq.size() > 2 ? xq[2] : 10'h3FF), 128'(10'h012));
        verifyBeats(10'h010, 10'h020, 3, 3, errs);
        checkOutput("t1_beats", 128'(errs), 128'(0));
        checkOutput("t1_last_pattern",
                    128'(sq.size() == 3 ? {sq[0][0], sq[1][0], sq[2][0]} : 3'b111), 128'(3'b001));
        checkOutput("t1_first_read", 128'(firstReadCyc - acceptCyc), 128'(1));
        checkOutput("t1_first_valid", 128'(firstValidCyc - acceptCyc), 128'(3));
        checkOutput("t1_done_after_mlast", 128'(doneCyc - mLastCyc), 128'(1));
        checkOutput("t1_en_match", 128'(enMismatch), 128'(0));

        $display("[TB] five tiles with the output side blocked");
        bus.sa_m_ready = 1'b0;
        applyStimulus(16'd4, 16'd5, 10'h100, 10'h200);
        repeat (60) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_beats_while_blocked", 128'(sq.size()), 128'(8));
        checkOutput("t2_reads_while_blocked", 128'(xq.size()), 128'(8));
        checkOutput("t2_busy_while_blocked", 128'(bus.busy), 128'(1));
        @(posedge clk); #1;
        bus.sa_m_ready = 1'b1;
        waitDone("t2", 400);
        verifyBeats(10'h100, 10'h200, 4, 20, errs);
        checkOutput("t2_beats", 128'(errs), 128'(0));
        checkOutput("t2_mlast_count", 128'(mLastCnt), 128'(5));
        checkOutput("t2_done_after_mlast", 128'(doneCyc - mLastCyc), 128'(1));

        $display("[TB] random s_ready, kdim=16, ntiles=3");
        readyIdx = 0;
        readyMode = 1;
        applyStimulus(16'd16, 16'd3, 10'h040, 10'h080);
        waitDone("t3", 2000);
        readyMode = 0;
        verifyBeats(10'h040, 10'h080, 16, 48, errs);
        checkOutput("t3_beats", 128'(errs), 128'(0));
        checkOutput("t3_beat_count", 128'(sq.size()), 128'(48));
        checkOutput("t3_stable_stall", 128'(stableErrs), 128'(0));

        $display("[TB] empty commands");
        applyStimulus(16'd0, 16'd7, 10'h000, 10'h000);
        waitDone("t4a", 20);
        checkOutput("t4a_reads", 128'(xq.size()), 128'(0));
        checkOutput("t4a_no_valid", 128'(firstValidCyc), 128'(-1));
        checkOutput("t4a_done_latency", 128'(doneCyc - acceptCyc), 128'(2));
        applyStimulus(16'd5, 16'd0, 10'h000, 10'h000);
        waitDone("t4b", 20);
        checkOutput("t4b_reads", 128'(xq.size()), 128'(0));
        checkOutput("t4b_no_valid", 128'(firstValidCyc), 128'(-1));
        checkOutput("t4b_done_latency", 128'(doneCyc - acceptCyc), 128'(2));

        $display("[TB] address wrap");
        applyStimulus(16'd3, 16'd2, 10'h3FE, 10'h3FF);
        waitDone("t5", 300);
        verifyAddrs(10'h3FE, 10'h3FF, 6, errs);
        checkOutput("t5_wrap_addrs", 128'(errs), 128'(0));
        checkOutput("t5_last_x_addr", 128'(xq.size() == 6 ? xq[5] : 10'h3FF), 128'(10'h003));

        $display("[TB] spurious completion while idle");
        @(posedge clk); #1;
        forceM = 1'b1;
        @(posedge clk); #1;
        forceM = 1'b0;
        @(negedge clk);
        checkOutput("t6_err_set", 128'(bus.err), 128'(1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("t6_err_held", 128'(bus.err), 128'(1));
        applyStimulus(16'd1, 16'd1, 10'h000, 10'h000);
        @(negedge clk);
        checkOutput("t6_err_cleared", 128'(bus.err), 128'(0));
        waitDone("t6", 100);

        $display("[TB] reset in the middle of a command");
        applyStimulus(16'd16, 16'd3, 10'h000, 10'h000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t7_reset_status", 128'(statusVec()), 128'(7'b1000000));
        @(posedge clk); #1;
        rst = 1'b0;
        snap = doneCnt;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("t7_no_done", 128'(doneCnt - snap), 128'(0));
        checkOutput("t7_idle", 128'(statusVec()), 128'(7'b1000000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
